operand_ctrl_sequencer: RTL and testbench

//  Clocked, parametrised successor to the combinational operand-flag decoder.

---
 rtl/operand_ctrl_pkg.sv | 24 ++
 rtl/operand_ctrl_sequencer_exec_window_counter.sv | 42 ++++
 rtl/operand_ctrl_sequencer.sv | 174 +++++++++++++++++
 tb/tb_operand_ctrl_sequencer.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/operand_ctrl_pkg.sv
// Shared definitions for the operand control sequencer: legacy opcode
// encodings, sequencer state encoding and a width helper.
package operand_ctrl_pkg;

    // Legacy opcode encodings; every value at or above OP_EXEC_MIN is an ALU op.
    localparam int unsigned OP_CLR_ALL  = 0;
    localparam int unsigned OP_WRITE    = 1;
    localparam int unsigned OP_CLEAR    = 2;
    localparam int unsigned OP_EXEC_MIN = 3;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DISPATCH = 2'd1,
        EXEC     = 2'd2
    } seq_state_e;

    // max(1, clog2(n)): a field that must hold at least one bit.
    function automatic int unsigned min1_clog2(input int unsigned n);
        int unsigned w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/operand_ctrl_sequencer_exec_window_counter.sv
// Down-counter that times the ALU execute window. Loaded with the number of
// execute cycles that follow the dispatch cycle, decremented once per EXEC cycle.
module exec_window_counter #(
    parameter int unsigned             CNT_W    = 1,
    parameter logic [CNT_W-1:0]        LOAD_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic             dec_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             zero_o
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Load has priority over decrement; otherwise hold.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = LOAD_VAL;
        end else if (dec_i) begin
            cnt_d = cnt_q - ONE;
        end
    end

    // Count register, cleared by the asynchronous reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/operand_ctrl_sequencer.sv
// Operand control sequencer: accepts instruction words over valid/ready,
// decodes the opcode and drives registered write/clear/read strobes for the
// operand register file, holding read strobes across the ALU execute window.
module operand_ctrl_sequencer
    import operand_ctrl_pkg::*;
#(
    parameter int unsigned INSTR_W     = 39,
    parameter int unsigned OPC_W       = 3,
    parameter int unsigned NUM_REGS    = 2,
    parameter int unsigned EXEC_CYCLES = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                instr_valid,
    output logic                instr_ready,
    input  logic [INSTR_W-1:0]  instruction,
    output logic [NUM_REGS-1:0] write_en,
    output logic [NUM_REGS-1:0] clear_en,
    output logic [NUM_REGS-1:0] read_en,
    output logic [OPC_W-1:0]    alu_op,
    output logic                busy,
    output logic                done,
    output logic                illegal
);

    localparam int unsigned      SEL_W    = min1_clog2(NUM_REGS);
    localparam int unsigned      CNT_W    = min1_clog2(EXEC_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(EXEC_CYCLES - 1);

    seq_state_e state_q, state_d;

    logic [OPC_W-1:0] opc;
    logic [SEL_W-1:0] sel;
    logic             accept;
    logic             opc_is_exec;
    logic             sel_legal;
    logic             exec_q;

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_after_dec;
    logic             cnt_zero;

    logic [NUM_REGS-1:0] write_q, write_d;
    logic [NUM_REGS-1:0] clear_q, clear_d;
    logic [NUM_REGS-1:0] read_q,  read_d;
    logic [OPC_W-1:0]    alu_op_q, alu_op_d;
    logic                ready_q, ready_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                illegal_q, illegal_d;

    // Operand payload bits below the select field are not used by the sequencer.
    logic unused_payload;
    assign unused_payload = ^instruction[INSTR_W-OPC_W-SEL_W-1:0];

    function automatic logic [NUM_REGS-1:0] sel_onehot(input logic [SEL_W-1:0] s);
        logic [NUM_REGS-1:0] oh;
        oh = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (32'(s) == i) oh[i] = 1'b1;
        end
        return oh;
    endfunction

    assign opc         = instruction[INSTR_W-1 -: OPC_W];
    assign sel         = instruction[INSTR_W-OPC_W-1 -: SEL_W];
    assign accept      = instr_valid && (state_q == IDLE);
    assign opc_is_exec = (opc >= OPC_W'(OP_EXEC_MIN));
    assign sel_legal   = (32'(sel) < NUM_REGS);

    exec_window_counter #(
        .CNT_W   (CNT_W),
        .LOAD_VAL(CNT_LOAD)
    ) u_exec_cnt (
        .clk_i (clk),
        .rst_i (reset),
        .load_i(accept),
        .dec_i (state_q == EXEC),
        .cnt_o (cnt),
        .zero_o(cnt_zero)
    );

    assign cnt_after_dec = cnt - CNT_ONE;

    // State register plus the latched "this is an ALU op" flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            exec_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) exec_q <= opc_is_exec;
        end
    end

    // Next-state: dispatch lasts one cycle, EXEC runs until the counter reaches 1.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:     if (accept) state_d = DISPATCH;
            DISPATCH: state_d = (exec_q && !cnt_zero) ? EXEC : IDLE;
            EXEC:     if (cnt == CNT_ONE) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Output next-values: strobes are computed one cycle ahead so every output
    // is a flop; done is raised for the cycle that will be the last strobe cycle.
    always_comb begin
        write_d   = '0;
        clear_d   = '0;
        read_d    = '0;
        alu_op_d  = '0;
        done_d    = 1'b0;
        illegal_d = 1'b0;
        ready_d   = (state_d == IDLE);
        busy_d    = (state_d != IDLE);
        if (accept) begin
            if (opc_is_exec) begin
                read_d   = '1;
                alu_op_d = opc;
                done_d   = (EXEC_CYCLES == 1);
            end else if (opc == OPC_W'(OP_CLR_ALL)) begin
                clear_d = '1;
                done_d  = 1'b1;
            end else begin
                done_d    = 1'b1;
                illegal_d = !sel_legal;
                if (sel_legal) begin
                    if (opc == OPC_W'(OP_WRITE)) write_d = sel_onehot(sel);
                    else                         clear_d = sel_onehot(sel);
                end
            end
        end else if (state_d == EXEC) begin
            read_d   = '1;
            alu_op_d = alu_op_q;
            done_d   = (state_q == DISPATCH) ? (cnt == CNT_ONE) : (cnt_after_dec == CNT_ONE);
        end
    end

    // Output registers; ready resets high because the reset state is IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            write_q   <= '0;
            clear_q   <= '0;
            read_q    <= '0;
            alu_op_q  <= '0;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            write_q   <= write_d;
            clear_q   <= clear_d;
            read_q    <= read_d;
            alu_op_q  <= alu_op_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            illegal_q <= illegal_d;
        end
    end

    assign write_en    = write_q;
    assign clear_en    = clear_q;
    assign read_en     = read_q;
    assign alu_op      = alu_op_q;
    assign instr_ready = ready_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign illegal     = illegal_q;

endmodule

// File: tb/tb_operand_ctrl_sequencer.sv
// Directed bench for operand_ctrl_sequencer. Instance A: NUM_REGS=4,
// EXEC_CYCLES=3. Instance B: NUM_REGS=5, EXEC_CYCLES=4 (3-bit select, so
// out-of-range selects such as 5 are representable).
module tb_operand_ctrl_sequencer;

    logic clk;
    logic reset;

    logic        a_valid, a_ready, a_busy, a_done, a_illegal;
    logic [38:0] a_instr;
    logic [3:0]  a_wr, a_clr, a_rd;
    logic [2:0]  a_alu;

    logic        b_valid, b_ready, b_busy, b_done, b_illegal;
    logic [38:0] b_instr;
    logic [4:0]  b_wr, b_clr, b_rd;
    logic [2:0]  b_alu;

    int total;
    int bad;

    operand_ctrl_sequencer #(
        .INSTR_W(39), .OPC_W(3), .NUM_REGS(4), .EXEC_CYCLES(3)
    ) dut_a (
        .clk(clk), .reset(reset), .instr_valid(a_valid), .instr_ready(a_ready),
        .instruction(a_instr), .write_en(a_wr), .clear_en(a_clr), .read_en(a_rd),
        .alu_op(a_alu), .busy(a_busy), .done(a_done), .illegal(a_illegal)
    );

    operand_ctrl_sequencer #(
        .INSTR_W(39), .OPC_W(3), .NUM_REGS(5), .EXEC_CYCLES(4)
    ) dut_b (
        .clk(clk), .reset(reset), .instr_valid(b_valid), .instr_ready(b_ready),
        .instruction(b_instr), .write_en(b_wr), .clear_en(b_clr), .read_en(b_rd),
        .alu_op(b_alu), .busy(b_busy), .done(b_done), .illegal(b_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Opcode in [38:36]; A's select is [35:34], B's select is [35:33].
    // Low payload bits carry a pattern that must not affect decoding.
    function automatic logic [38:0] mk_a(input logic [2:0] op, input logic [1:0] s);
        logic [38:0] w;
        w = 39'h0_5A5A_5A5A;
        w[38:36] = op;
        w[35:34] = s;
        return w;
    endfunction

    function automatic logic [38:0] mk_b(input logic [2:0] op, input logic [2:0] s);
        logic [38:0] w;
        w = 39'h0_1234_5678;
        w[38:36] = op;
        w[35:33] = s;
        return w;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        reset   = 1'b1;
        a_valid = 1'b0;
        b_valid = 1'b0;
        a_instr = '0;
        b_instr = '0;

        // Reset state
        step();
        step();
        check("rst_a_busy", a_busy, 0);
        check("rst_a_strobes", {a_wr, a_clr, a_rd}, 0);
        check("rst_a_done", {a_done, a_illegal, a_alu}, 0);
        check("rst_b_strobes", {b_wr, b_clr, b_rd, b_alu}, 0);
        reset = 1'b0;
        step();
        check("rst_a_ready", a_ready, 1);
        check("rst_b_ready", b_ready, 1);

        // WRITE sel=1 on A
        a_instr = mk_a(3'b001, 2'd1);
        a_valid = 1'b1;
        step();
        a_valid = 1'b0;
        check("wr_en", a_wr, 4'b0010);
        check("wr_done", a_done, 1);
        check("wr_ready_low", {a_ready, a_busy}, 2'b01);
        check("wr_other", {a_clr, a_rd, a_illegal}, 0);
        step();
        check("wr_en_off", a_wr, 0);
        check("wr_done_off", a_done, 0);
        check("wr_ready_back", {a_ready, a_busy}, 2'b10);

        // EXEC opcode 101 on A, window of 3
        a_instr = mk_a(3'b101, 2'd3);
        a_valid = 1'b1;
        step();
        a_valid = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            check($sformatf("ex_rd_c%0d", c), a_rd, 4'b1111);
            check($sformatf("ex_alu_c%0d", c), a_alu, 3'b101);
            check($sformatf("ex_done_c%0d", c), a_done, (c == 3) ? 1 : 0);
            check($sformatf("ex_ready_c%0d", c), a_ready, 0);
            step();
        end
        check("ex_rd_off", {a_rd, a_alu, a_done}, 0);
        check("ex_ready_back", {a_ready, a_busy}, 2'b10);

        // Back-to-back CLR_ALL then WRITE sel=0 with valid held high
        a_instr = mk_a(3'b000, 2'd2);
        a_valid = 1'b1;
        step();
        check("b2b_clr_all", a_clr, 4'b1111);
        check("b2b_clr_done", a_done, 1);
        a_instr = mk_a(3'b001, 2'd0);
        step();
        check("b2b_gap", {a_wr, a_clr, a_done}, 0);
        check("b2b_gap_ready", a_ready, 1);
        step();
        a_valid = 1'b0;
        check("b2b_wr", a_wr, 4'b0001);
        check("b2b_wr_done", a_done, 1);
        step();
        check("b2b_wr_off", a_wr, 0);

        // valid asserted during EXEC is held off until IDLE
        a_instr = mk_a(3'b011, 2'd0);
        a_valid = 1'b1;
        step();
        a_instr = mk_a(3'b001, 2'd2);
        check("hold_rd1", a_rd, 4'b1111);
        check("hold_alu", a_alu, 3'b011);
        step();
        check("hold_no_wr2", a_wr, 0);
        step();
        check("hold_no_wr3", a_wr, 0);
        check("hold_done3", a_done, 1);
        step();
        check("hold_idle", {a_ready, a_wr, a_rd}, {1'b1, 8'h00});
        step();
        a_valid = 1'b0;
        check("hold_wr", a_wr, 4'b0100);
        check("hold_wr_done", a_done, 1);
        step();

        // Illegal select on B
        b_instr = mk_b(3'b010, 3'd5);
        b_valid = 1'b1;
        step();
        b_valid = 1'b0;
        check("ill_strobes", {b_wr, b_clr, b_rd}, 0);
        check("ill_flags", {b_illegal, b_done}, 2'b11);
        step();
        check("ill_off", {b_illegal, b_done}, 0);
        check("ill_ready", b_ready, 1);
        b_instr = mk_b(3'b001, 3'd7);
        b_valid = 1'b1;
        step();
        b_valid = 1'b0;
        check("ill_wr7", {b_wr, b_illegal, b_done}, {5'b0, 2'b11});
        step();
        b_instr = mk_b(3'b010, 3'd4);
        b_valid = 1'b1;
        step();
        b_valid = 1'b0;
        check("clr_sel4", {b_clr, b_illegal}, {5'b10000, 1'b0});
        step();
        b_instr = mk_b(3'b000, 3'd6);
        b_valid = 1'b1;
        step();
        b_valid = 1'b0;
        check("clr_all_b", {b_clr, b_illegal}, {5'b11111, 1'b0});
        step();

        // Reset mid-EXEC on B (window of 4), asserted in cycle 2
        b_instr = mk_b(3'b111, 3'd0);
        b_valid = 1'b1;
        step();
        b_valid = 1'b0;
        check("mrst_rd1", b_rd, 5'b11111);
        step();
        check("mrst_rd2", b_rd, 5'b11111);
        check("mrst_busy2", b_busy, 1);
        #1 reset = 1'b1;
        #1;
        check("mrst_rd_drop", b_rd, 0);
        check("mrst_busy_drop", b_busy, 0);
        check("mrst_alu_drop", {b_alu, b_done}, 0);
        step();
        reset = 1'b0;
        step();
        check("mrst_ready", {b_ready, b_busy}, 2'b10);
        b_instr = mk_b(3'b001, 3'd3);
        b_valid = 1'b1;
        step();
        b_valid = 1'b0;
        check("mrst_wr3", b_wr, 5'b01000);
        step();

        // Full 4-cycle window on B
        b_instr = mk_b(3'b100, 3'd2);
        b_valid = 1'b1;
        step();
        b_valid = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            check($sformatf("bex_rd_c%0d", c), {b_rd, b_alu}, {5'b11111, 3'b100});
            check($sformatf("bex_done_c%0d", c), b_done, (c == 4) ? 1 : 0);
            step();
        end
        check("bex_end", {b_ready, b_rd, b_done}, {1'b1, 6'h00});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
